// File: rtl/sa_out_collector.sv
// sa_out_collector: drain stage behind the systolic array output scan chain.
// After a context switch it shifts X result columns out of the array.
// Each column is reduced lane by lane from OC_W to OUT_W and stored in a
// small column FIFO. The FIFO head is offered on a valid/ready stream.
// Optional feature macro: SAURIA_OUTCOL_SAT_EN. When it is defined, lanes are
// signed-saturated and o_sat is sticky. Otherwise lanes are truncated to their
// low OUT_W bits and o_sat is tied low.
module sa_out_collector #(
    parameter int X          = 3,
    parameter int Y          = 3,
    parameter int OC_W       = 48,
    parameter int OUT_W      = 32,
    parameter int FIFO_DEPTH = 2,
    parameter int CI_W       = (X > 1) ? $clog2(X) : 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_cscan_en,
    input  logic [Y*OC_W-1:0]    i_c_arr,
    output logic [Y*OUT_W-1:0]   o_data,
    output logic [CI_W-1:0]      o_col,
    output logic                 o_last,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_sat
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [CI_W-1:0]  COL_LAST = CI_W'(X - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DRAIN} state_t;

    state_t               state_q, state_d;
    logic [CI_W-1:0]      shift_cnt_q;
    logic [CNT_W-1:0]     count_q;
    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic                 push, pop, start_acc;

    logic [Y*OUT_W-1:0]   red_p0;
    logic [Y*OUT_W-1:0]   fifo_data_p1 [FIFO_DEPTH];
    logic [CI_W-1:0]      fifo_col_p1  [FIFO_DEPTH];
    logic                 fifo_last_p1 [FIFO_DEPTH];

`ifdef SAURIA_OUTCOL_SAT_EN
    // A lane clips when its bits above the OUT_W sign bit are not all equal to that sign bit.
    function automatic logic lane_clipped(input logic signed [OC_W-1:0] v);
        logic [OC_W-OUT_W:0] hi;
        hi = v[OC_W-1:OUT_W-1];
        return !((&hi) || !(|hi));
    endfunction

    function automatic logic signed [OUT_W-1:0] sat_lane(input logic signed [OC_W-1:0] v);
        if (lane_clipped(v))
            return v[OC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
        return v[OUT_W-1:0];
    endfunction

    logic [Y-1:0] clip_p0;
    logic         sat_q;

    // Per-lane saturation of the column currently at the chain output
    always_comb begin
        red_p0  = '0;
        clip_p0 = '0;
        for (int j = 0; j < Y; j++) begin
            red_p0[j*OUT_W +: OUT_W] = sat_lane(i_c_arr[j*OC_W +: OC_W]);
            clip_p0[j]               = lane_clipped(i_c_arr[j*OC_W +: OC_W]);
        end
    end

    // Sticky clip flag, cleared by an accepted start
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            sat_q <= 1'b0;
        else if (start_acc)
            sat_q <= 1'b0;
        else if (push && (|clip_p0))
            sat_q <= 1'b1;
    end

    assign o_sat = sat_q;
`else
    function automatic logic signed [OUT_W-1:0] trunc_lane(input logic signed [OUT_W-1:0] lo);
        return lo;
    endfunction

    logic unused_hi;
    assign unused_hi = ^i_c_arr;

    // Per-lane truncation keeps only the low OUT_W bits
    always_comb begin
        red_p0 = '0;
        for (int j = 0; j < Y; j++)
            red_p0[j*OUT_W +: OUT_W] = trunc_lane(i_c_arr[j*OC_W +: OUT_W]);
    end

    assign o_sat = 1'b0;
`endif

    // Shifting is allowed only while the FIFO has room, so back-pressure stalls the chain
    assign push       = (state_q == SHIFT) && (count_q < DEPTH_C);
    assign o_cscan_en = push;
    assign o_valid    = (count_q != '0);
    assign pop        = o_valid && i_ready;
    assign start_acc  = (state_q == IDLE) && i_start;
    assign o_busy     = (state_q != IDLE);
    assign o_data     = o_valid ? fifo_data_p1[rd_ptr_q] : '0;
    assign o_col      = o_valid ? fifo_col_p1[rd_ptr_q]  : '0;
    assign o_last     = o_valid && fifo_last_p1[rd_ptr_q];
    assign o_done     = pop && o_last;

    // Next-state logic for the drain sequencer
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_start) state_d = SHIFT;
            SHIFT:   if (push && (shift_cnt_q == COL_LAST)) state_d = DRAIN;
            DRAIN:   if (pop && o_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Control registers: state, shift counter, FIFO pointers and occupancy
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= IDLE;
            shift_cnt_q <= '0;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            state_q <= state_d;
            if (start_acc)
                shift_cnt_q <= '0;
            else if (push)
                shift_cnt_q <= shift_cnt_q + CI_W'(1);
            if (push)
                wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
            if (pop)
                rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
            if (push && !pop)
                count_q <= count_q + CNT_W'(1);
            else if (pop && !push)
                count_q <= count_q - CNT_W'(1);
        end
    end

    // ---- stage p1: column FIFO storage (data path, not reset) ----
    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_data_p1[wr_ptr_q] <= red_p0;
            fifo_col_p1[wr_ptr_q]  <= shift_cnt_q;
            fifo_last_p1[wr_ptr_q] <= (shift_cnt_q == COL_LAST);
        end
    end

endmodule

// File: tb/tb_sa_out_collector.sv
// Directed self-checking bench for sa_out_collector (X=3 and X=4 instances).
module tb_sa_out_collector;
    localparam int Y = 3, OC_W = 48, OUT_W = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic start3 = 1'b0, ready3 = 1'b0, start4 = 1'b0, ready4 = 1'b0;
    logic ovr = 1'b0;
    logic [Y*OC_W-1:0]  c3, c4;
    logic [Y*OUT_W-1:0] data3, data4;
    logic [1:0] col3, col4;
    logic busy3, done3, cscan3, last3, valid3, sat3;
    logic busy4, done4, cscan4, last4, valid4, sat4;

    sa_out_collector #(.X(3), .Y(Y), .OC_W(OC_W), .OUT_W(OUT_W), .FIFO_DEPTH(2)) dut3 (
        .i_clk(clk), .i_rst(rst), .i_start(start3), .o_busy(busy3), .o_done(done3),
        .o_cscan_en(cscan3), .i_c_arr(c3), .o_data(data3), .o_col(col3), .o_last(last3),
        .o_valid(valid3), .i_ready(ready3), .o_sat(sat3));

    sa_out_collector #(.X(4), .Y(Y), .OC_W(OC_W), .OUT_W(OUT_W), .FIFO_DEPTH(2)) dut4 (
        .i_clk(clk), .i_rst(rst), .i_start(start4), .o_busy(busy4), .o_done(done4),
        .o_cscan_en(cscan4), .i_c_arr(c4), .o_data(data4), .o_col(col4), .o_last(last4),
        .o_valid(valid4), .i_ready(ready4), .o_sat(sat4));

    int n_cmp = 0, n_err = 0;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Array output chain model: column index advances on every scan-enabled edge
    int sh3 = 0, base3 = 0, sh4 = 0, base4 = 0;
    always @(posedge clk) if (cscan3) sh3 <= sh3 + 1;
    always @(posedge clk) if (cscan4) sh4 <= sh4 + 1;

    always_comb begin
        c3 = '0;
        c4 = '0;
        for (int j = 0; j < Y; j++) begin
            c3[j*OC_W +: OC_W] = OC_W'(16 * (sh3 - base3) + j);
            c4[j*OC_W +: OC_W] = OC_W'(16 * (sh4 - base4) + j);
        end
        if (ovr) begin
            c3[0*OC_W +: OC_W] = 48'h0001_0000_0005;
            c3[1*OC_W +: OC_W] = 48'hFF00_0000_0000;
        end
    end

    function automatic logic [Y*OUT_W-1:0] exp_col(input int k);
        logic [Y*OUT_W-1:0] r;
        r = '0;
        for (int j = 0; j < Y; j++) r[j*OUT_W +: OUT_W] = OUT_W'(16 * k + j);
        return r;
    endfunction

    // Beat/scan monitors, sampled mid-cycle
    int n_cscan3 = 0, n_done3 = 0, n_cscan4 = 0, n_done4 = 0, occ4 = 0;
    int q_col3[$], q_col4[$];
    logic [Y*OUT_W-1:0] q_data3[$], q_data4[$];
    bit q_last3[$], q_last4[$];
    bit chk4 = 0;

    always @(negedge clk) if (!rst) begin
        if (cscan3) n_cscan3 <= n_cscan3 + 1;
        if (done3)  n_done3  <= n_done3 + 1;
        if (valid3 && ready3) begin
            q_col3.push_back(int'(col3));
            q_data3.push_back(data3);
            q_last3.push_back(last3);
        end
    end

    always @(negedge clk) if (!rst) begin
        automatic int nxt;
        if (cscan4) n_cscan4 <= n_cscan4 + 1;
        if (done4)  n_done4  <= n_done4 + 1;
        if (valid4 && ready4) begin
            q_col4.push_back(int'(col4));
            q_data4.push_back(data4);
            q_last4.push_back(last4);
        end
        if (chk4) begin
            check_eq("x4_valid_vs_occupancy", valid4, occ4 != 0);
            nxt = occ4 + int'(cscan4) - int'(valid4 && ready4);
            check_eq("x4_occupancy_le_depth", nxt <= 2, 1'b1);
            occ4 <= nxt;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic verify3(input string tag, input int q0, input int n0, input int d0);
        check_eq({tag, "_ncscan"}, n_cscan3 - n0, 3);
        check_eq({tag, "_ndone"}, n_done3 - d0, 1);
        check_eq({tag, "_nbeats"}, q_col3.size() - q0, 3);
        for (int k = 0; k < 3; k++) begin
            if (q0 + k < q_col3.size()) begin
                check_eq({tag, "_col"}, q_col3[q0+k], k);
                check_eq({tag, "_data"}, q_data3[q0+k], exp_col(k));
                check_eq({tag, "_last"}, q_last3[q0+k], k == 2);
            end
        end
    endtask

    initial begin
        int q0, n0, d0;
        logic [Y*OUT_W-1:0] sat_exp;

        // Reset state
        cyc(); #1;
        check_eq("rst_busy", busy3, 0);
        check_eq("rst_done", done3, 0);
        check_eq("rst_cscan", cscan3, 0);
        check_eq("rst_valid", valid3, 0);
        check_eq("rst_sat", sat3, 0);
        check_eq("rst_data", data3, 0);
        check_eq("rst_col", col3, 0);
        check_eq("rst_last", last3, 0);
        cyc(); rst = 1'b0;
        cyc();

        // Streaming drain with i_ready held high
        base3 = sh3; ready3 = 1'b1;
        q0 = q_col3.size(); n0 = n_cscan3; d0 = n_done3;
        cyc(); start3 = 1'b1; #1;
        check_eq("t0_busy", busy3, 0);
        check_eq("t0_cscan", cscan3, 0);
        cyc(); start3 = 1'b0; #1;
        check_eq("t1_cscan", cscan3, 1);
        check_eq("t1_valid", valid3, 0);
        check_eq("t1_busy", busy3, 1);
        cyc(); #1;
        check_eq("t2_valid", valid3, 1);
        check_eq("t2_col", col3, 0);
        check_eq("t2_data", data3, exp_col(0));
        check_eq("t2_last", last3, 0);
        check_eq("t2_cscan", cscan3, 1);
        cyc(); #1;
        check_eq("t3_col", col3, 1);
        check_eq("t3_data", data3, exp_col(1));
        check_eq("t3_cscan", cscan3, 1);
        check_eq("t3_done", done3, 0);
        cyc(); #1;
        check_eq("t4_col", col3, 2);
        check_eq("t4_last", last3, 1);
        check_eq("t4_done", done3, 1);
        check_eq("t4_cscan", cscan3, 0);
        check_eq("t4_data", data3, exp_col(2));
        cyc(); #1;
        check_eq("t5_busy", busy3, 0);
        check_eq("t5_valid", valid3, 0);
        check_eq("t5_data", data3, 0);
        check_eq("t5_done", done3, 0);
        cyc(); cyc();
        verify3("stream", q0, n0, d0);

        // Back-pressure: consumer stalled, FIFO fills at two columns
        base3 = sh3; ready3 = 1'b0;
        q0 = q_col3.size(); n0 = n_cscan3; d0 = n_done3;
        cyc(); start3 = 1'b1;
        cyc(); start3 = 1'b0; #1;
        check_eq("bp_t1_cscan", cscan3, 1);
        cyc(); #1;
        check_eq("bp_t2_cscan", cscan3, 1);
        check_eq("bp_t2_col", col3, 0);
        cyc(); #1;
        check_eq("bp_t3_cscan", cscan3, 0);
        check_eq("bp_t3_valid", valid3, 1);
        cyc(); ready3 = 1'b1; #1;
        check_eq("bp_t4_cscan", cscan3, 0);
        check_eq("bp_t4_col", col3, 0);
        cyc(); #1;
        check_eq("bp_t5_cscan", cscan3, 1);
        check_eq("bp_t5_col", col3, 1);
        cyc(); #1;
        check_eq("bp_t6_done", done3, 1);
        cyc(); cyc(); cyc();
        check_eq("bp_idle", busy3, 0);
        verify3("backpressure", q0, n0, d0);

        // A start while busy must be ignored
        base3 = sh3; ready3 = 1'b1;
        q0 = q_col3.size(); n0 = n_cscan3; d0 = n_done3;
        cyc(); start3 = 1'b1;
        cyc(); start3 = 1'b0;
        cyc(); start3 = 1'b1;
        cyc(); start3 = 1'b0;
        repeat (8) cyc();
        check_eq("restart_busy", busy3, 0);
        verify3("restart", q0, n0, d0);

        // Reset after the first capture, then a fresh drain
        base3 = sh3; ready3 = 1'b0;
        cyc(); start3 = 1'b1;
        cyc(); start3 = 1'b0;
        cyc(); #1;
        check_eq("rstmid_valid_before", valid3, 1);
        rst = 1'b1; #1;
        check_eq("rstmid_valid", valid3, 0);
        check_eq("rstmid_busy", busy3, 0);
        check_eq("rstmid_cscan", cscan3, 0);
        cyc(); rst = 1'b0;
        cyc();
        base3 = sh3; ready3 = 1'b1;
        q0 = q_col3.size(); n0 = n_cscan3; d0 = n_done3;
        cyc(); start3 = 1'b1;
        cyc(); start3 = 1'b0;
        repeat (7) cyc();
        verify3("after_rst", q0, n0, d0);

        // Lane reduction: out-of-range positive and negative lanes
`ifdef SAURIA_OUTCOL_SAT_EN
        sat_exp = {32'h0000_0002, 32'h8000_0000, 32'h7FFF_FFFF};
`else
        sat_exp = {32'h0000_0002, 32'h0000_0000, 32'h0000_0005};
`endif
        base3 = sh3; ready3 = 1'b1; ovr = 1'b1;
        cyc(); start3 = 1'b1;
        cyc(); start3 = 1'b0;
        cyc(); #1;
        check_eq("red_col0_data", data3, sat_exp);
        repeat (5) cyc();
`ifdef SAURIA_OUTCOL_SAT_EN
        check_eq("red_sat_sticky", sat3, 1);
`else
        check_eq("red_sat_sticky", sat3, 0);
`endif
        ovr = 1'b0; base3 = sh3;
        cyc(); start3 = 1'b1;
        cyc(); start3 = 1'b0; #1;
        check_eq("red_sat_cleared", sat3, 0);
        repeat (6) cyc();
        check_eq("red_sat_clean_drain", sat3, 0);

        // X=4 with alternating ready
        base4 = sh4; chk4 = 1;
        q0 = q_col4.size(); n0 = n_cscan4; d0 = n_done4;
        cyc(); start4 = 1'b1; ready4 = 1'b1;
        cyc(); start4 = 1'b0; ready4 = 1'b0;
        for (int i = 0; i < 18; i++) begin
            cyc(); ready4 = ~ready4;
        end
        cyc(); chk4 = 0; ready4 = 1'b0;
        cyc();
        check_eq("x4_busy", busy4, 0);
        check_eq("x4_ncscan", n_cscan4 - n0, 4);
        check_eq("x4_ndone", n_done4 - d0, 1);
        check_eq("x4_nbeats", q_col4.size() - q0, 4);
        for (int k = 0; k < 4; k++) begin
            if (q0 + k < q_col4.size()) begin
                check_eq("x4_col", q_col4[q0+k], k);
                check_eq("x4_data", q_data4[q0+k], exp_col(k));
                check_eq("x4_last", q_last4[q0+k], k == 3);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Absolute time bound so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "time limit");
    end
endmodule
